// File: rtl/map_mover.sv
// map_mover: latches level data from the map block, owns both player tiles
// and arbitrates their move requests against walls, map edge and each other.
module map_mover #(
    parameter int COLS = 16,
    parameter int ROWS = 12,
    parameter int CW   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_level,
    input  logic [ROWS*COLS-1:0] mask,
    input  logic [9:0]           p1_init_x,
    input  logic [9:0]           p1_init_y,
    input  logic [9:0]           p2_init_x,
    input  logic [9:0]           p2_init_y,
    input  logic                 p1_req,
    input  logic [1:0]           p1_dir,
    input  logic                 p2_req,
    input  logic [1:0]           p2_dir,
    output logic                 p1_ack,
    output logic                 p1_ok,
    output logic                 p2_ack,
    output logic                 p2_ok,
    output logic [9:0]           p1_x,
    output logic [9:0]           p1_y,
    output logic [9:0]           p2_x,
    output logic [9:0]           p2_y,
    output logic [CW-1:0]        p1_moves,
    output logic [CW-1:0]        p2_moves,
    output logic                 ready
);

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam logic signed [10:0] COLS_S = 11'(COLS);
    localparam logic signed [10:0] ROWS_S = 11'(ROWS);

    typedef enum logic [2:0] {
        S_WAIT,
        S_LOAD,
        S_IDLE,
        S_CHECK,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    mask_q, mask_d;
    logic [9:0]      p1x_q, p1x_d, p1y_q, p1y_d;
    logic [9:0]      p2x_q, p2x_d, p2y_q, p2y_d;
    logic [CW-1:0]   p1m_q, p1m_d, p2m_q, p2m_d;
    logic            rr_q, rr_d;
    logic            sel_q, sel_d;
    logic [1:0]      dir_q, dir_d;
    logic            ok_q, ok_d;

    logic [9:0]        cur_x, cur_y, oth_x, oth_y;
    logic signed [10:0] tx, ty;
    logic              in_range, wall, overlap, deny;
    logic [IW-1:0]     bit_idx;

    // Target tile of the player being served (sel_q: 0 = P1, 1 = P2)
    always_comb begin
        cur_x = sel_q ? p2x_q : p1x_q;
        cur_y = sel_q ? p2y_q : p1y_q;
        oth_x = sel_q ? p1x_q : p2x_q;
        oth_y = sel_q ? p1y_q : p2y_q;
        tx = $signed({1'b0, cur_x});
        ty = $signed({1'b0, cur_y});
        unique case (dir_q)
            2'd0: ty = ty - 11'sd1;
            2'd1: ty = ty + 11'sd1;
            2'd2: tx = tx - 11'sd1;
            2'd3: tx = tx + 11'sd1;
        endcase
        in_range = !tx[10] && (tx < COLS_S) && !ty[10] && (ty < ROWS_S);
        bit_idx = IW'(N - 1) - (ty[IW-1:0] * IW'(COLS) + tx[IW-1:0]);
        wall = mask_q[bit_idx];
        overlap = (tx == {1'b0, oth_x}) && (ty == {1'b0, oth_y});
        deny = !in_range || wall || overlap;
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        p1x_d   = p1x_q;
        p1y_d   = p1y_q;
        p2x_d   = p2x_q;
        p2y_d   = p2y_q;
        p1m_d   = p1m_q;
        p2m_d   = p2m_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        ok_d    = ok_q;
        unique case (state_q)
            S_WAIT: ;
            S_LOAD: begin
                mask_d  = mask;
                p1x_d   = p1_init_x;
                p1y_d   = p1_init_y;
                p2x_d   = p2_init_x;
                p2y_d   = p2_init_y;
                p1m_d   = '0;
                p2m_d   = '0;
                rr_d    = 1'b0;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!new_level && (p1_req || p2_req)) begin
                    if (p1_req && p2_req) begin
                        sel_d = rr_q;
                        rr_d  = ~rr_q;
                    end else begin
                        sel_d = !p1_req;
                    end
                    dir_d   = sel_d ? p2_dir : p1_dir;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                ok_d    = !deny;
                state_d = S_RESP;
                // A level reload in this cycle aborts the move entirely
                if (!deny && !new_level) begin
                    if (sel_q) begin
                        p2x_d = tx[9:0];
                        p2y_d = ty[9:0];
                        p2m_d = (&p2m_q) ? p2m_q : p2m_q + 1'b1;
                    end else begin
                        p1x_d = tx[9:0];
                        p1y_d = ty[9:0];
                        p1m_d = (&p1m_q) ? p1m_q : p1m_q + 1'b1;
                    end
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_WAIT;
        endcase
        if (new_level) begin
            state_d = S_LOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            mask_q  <= '1;
            p1x_q   <= '0;
            p1y_q   <= '0;
            p2x_q   <= '0;
            p2y_q   <= '0;
            p1m_q   <= '0;
            p2m_q   <= '0;
            rr_q    <= 1'b0;
            sel_q   <= 1'b0;
            dir_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            p1x_q   <= p1x_d;
            p1y_q   <= p1y_d;
            p2x_q   <= p2x_d;
            p2y_q   <= p2y_d;
            p1m_q   <= p1m_d;
            p2m_q   <= p2m_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            ok_q    <= ok_d;
        end
    end

    assign p1_ack   = (state_q == S_RESP) && !sel_q;
    assign p2_ack   = (state_q == S_RESP) && sel_q;
    assign p1_ok    = p1_ack && ok_q;
    assign p2_ok    = p2_ack && ok_q;
    assign p1_x     = p1x_q;
    assign p1_y     = p1y_q;
    assign p2_x     = p2x_q;
    assign p2_y     = p2y_q;
    assign p1_moves = p1m_q;
    assign p2_moves = p2m_q;
    assign ready    = (state_q == S_IDLE);

endmodule

// File: tb/tb_map_mover.sv
// Directed self-checking bench for map_mover: load, walls, edges,
// overlap, round-robin arbitration, reload abort and async reset.
module tb_map_mover;

    localparam int N = 192;

    logic         clk = 1'b0;
    logic         reset;
    logic         new_level;
    logic [N-1:0] mask;
    logic [9:0]   p1_init_x, p1_init_y, p2_init_x, p2_init_y;
    logic         p1_req, p2_req;
    logic [1:0]   p1_dir, p2_dir;
    logic         p1_ack, p1_ok, p2_ack, p2_ok;
    logic [9:0]   p1_x, p1_y, p2_x, p2_y;
    logic [15:0]  p1_moves, p2_moves;
    logic         ready;

    int checks = 0;
    int errors = 0;

    map_mover dut (
        .clk(clk), .reset(reset), .new_level(new_level), .mask(mask),
        .p1_init_x(p1_init_x), .p1_init_y(p1_init_y),
        .p2_init_x(p2_init_x), .p2_init_y(p2_init_y),
        .p1_req(p1_req), .p1_dir(p1_dir), .p2_req(p2_req), .p2_dir(p2_dir),
        .p1_ack(p1_ack), .p1_ok(p1_ok), .p2_ack(p2_ack), .p2_ok(p2_ok),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .p1_moves(p1_moves), .p2_moves(p2_moves), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic load_level(input logic [N-1:0] m, input int x1, input int y1,
                              input int x2, input int y2);
        @(negedge clk);
        mask = m;
        p1_init_x = 10'(x1); p1_init_y = 10'(y1);
        p2_init_x = 10'(x2); p2_init_y = 10'(y2);
        new_level = 1'b1;
        @(negedge clk);
        new_level = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ack(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (p1_ack || p2_ack) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Issue one request; returns observed ack/ok and edges to ack (-1 = none)
    task automatic do_req(input int pl, input logic [1:0] d, output logic a1,
                          output logic a2, output logic ok, output int cyc);
        if (pl == 1) begin p1_req = 1'b1; p1_dir = d; end
        else begin p2_req = 1'b1; p2_dir = d; end
        wait_ack(cyc);
        a1 = p1_ack; a2 = p2_ack;
        ok = (pl == 1) ? p1_ok : p2_ok;
        p1_req = 1'b0; p2_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", ready); end
        checks++; if ({p1_x, p1_y, p2_x, p2_y} !== 40'd0) begin errors++; $display("FAIL rst_pos got=%h want=0", {p1_x, p1_y, p2_x, p2_y}); end
        checks++; if ({p1_moves, p2_moves} !== 32'd0) begin errors++; $display("FAIL rst_moves got=%h want=0", {p1_moves, p2_moves}); end
        checks++; if ({p1_ack, p1_ok, p2_ack, p2_ok} !== 4'd0) begin errors++; $display("FAIL rst_ack got=%b want=0000", {p1_ack, p1_ok, p2_ack, p2_ok}); end
        reset = 1'b0;
        p1_req = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (ready !== 1'b0 || p1_ack !== 1'b0) begin errors++; $display("FAIL wait_stays ready=%b ack=%b want 0 0", ready, p1_ack); end
        p1_req = 1'b0;
    endtask

    task automatic test_load();
        load_level({16'hFFFF, 176'd0}, 2, 1, 14, 8);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL load_ready got=%b want=1", ready); end
        checks++; if (p1_x !== 10'd2 || p1_y !== 10'd1) begin errors++; $display("FAIL load_p1 got=(%0d,%0d) want=(2,1)", p1_x, p1_y); end
        checks++; if (p2_x !== 10'd14 || p2_y !== 10'd8) begin errors++; $display("FAIL load_p2 got=(%0d,%0d) want=(14,8)", p2_x, p2_y); end
        checks++; if (p1_moves !== 16'd0 || p2_moves !== 16'd0) begin errors++; $display("FAIL load_moves got=%0d,%0d want=0,0", p1_moves, p2_moves); end
    endtask

    task automatic test_wall_and_move();
        logic a1, a2, ok;
        int cyc;
        do_req(1, 2'd0, a1, a2, ok, cyc);
        checks++; if (a1 !== 1'b1 || a2 !== 1'b0 || ok !== 1'b0) begin errors++; $display("FAIL wall_resp got a1=%b a2=%b ok=%b want 1 0 0", a1, a2, ok); end
        checks++; if (p1_x !== 10'd2 || p1_y !== 10'd1) begin errors++; $display("FAIL wall_pos got=(%0d,%0d) want=(2,1)", p1_x, p1_y); end
        do_req(1, 2'd3, a1, a2, ok, cyc);
        checks++; if (ok !== 1'b1 || a1 !== 1'b1) begin errors++; $display("FAIL move_ok got ok=%b ack=%b want 1 1", ok, a1); end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL move_latency got=%0d want=2", cyc); end
        checks++; if (p1_x !== 10'd3 || p1_y !== 10'd1 || p1_moves !== 16'd1) begin errors++; $display("FAIL move_pos got=(%0d,%0d) m=%0d want=(3,1) m=1", p1_x, p1_y, p1_moves); end
        checks++; if (p1_ok !== 1'b0 || p1_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse got ack=%b ok=%b want 0 0", p1_ack, p1_ok); end
    endtask

    task automatic test_round_robin();
        int cyc;
        load_level('0, 3, 3, 8, 8);
        for (int r = 0; r < 2; r++) begin
            p1_req = 1'b1; p1_dir = 2'd3;
            p2_req = 1'b1; p2_dir = 2'd3;
            wait_ack(cyc);
            checks++; if (p1_ack !== (r == 0) || p2_ack !== (r == 1)) begin errors++; $display("FAIL rr_first%0d got a1=%b a2=%b want %b %b", r, p1_ack, p2_ack, r == 0, r == 1); end
            if (r == 0) p1_req = 1'b0; else p2_req = 1'b0;
            wait_ack(cyc);
            checks++; if (p1_ack !== (r == 1) || p2_ack !== (r == 0)) begin errors++; $display("FAIL rr_second%0d got a1=%b a2=%b want %b %b", r, p1_ack, p2_ack, r == 1, r == 0); end
            p1_req = 1'b0; p2_req = 1'b0;
            @(negedge clk);
        end
        checks++; if (p1_x !== 10'd5 || p2_x !== 10'd10) begin errors++; $display("FAIL rr_pos got p1x=%0d p2x=%0d want 5 10", p1_x, p2_x); end
        checks++; if (p1_moves !== 16'd2 || p2_moves !== 16'd2) begin errors++; $display("FAIL rr_moves got=%0d,%0d want=2,2", p1_moves, p2_moves); end
    endtask

    task automatic test_overlap();
        logic a1, a2, ok;
        int cyc;
        load_level('0, 5, 4, 6, 4);
        do_req(1, 2'd3, a1, a2, ok, cyc);
        checks++; if (a1 !== 1'b1 || ok !== 1'b0) begin errors++; $display("FAIL ovl_p1 got ack=%b ok=%b want 1 0", a1, ok); end
        do_req(2, 2'd2, a1, a2, ok, cyc);
        checks++; if (a2 !== 1'b1 || ok !== 1'b0) begin errors++; $display("FAIL ovl_p2 got ack=%b ok=%b want 1 0", a2, ok); end
        checks++; if (p1_x !== 10'd5 || p2_x !== 10'd6 || p1_y !== 10'd4 || p2_y !== 10'd4) begin errors++; $display("FAIL ovl_pos got (%0d,%0d) (%0d,%0d)", p1_x, p1_y, p2_x, p2_y); end
    endtask

    task automatic test_edges();
        logic a1, a2, ok;
        int cyc;
        logic [1:0] dirs [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
        load_level('0, 0, 0, 15, 11);
        for (int k = 0; k < 4; k++) begin
            do_req(k < 2 ? 1 : 2, dirs[k], a1, a2, ok, cyc);
            checks++; if (cyc < 0 || ok !== 1'b0) begin errors++; $display("FAIL edge%0d got cyc=%0d ok=%b want ack ok=0", k, cyc, ok); end
        end
        checks++; if ({p1_x, p1_y, p2_x, p2_y} !== {10'd0, 10'd0, 10'd15, 10'd11}) begin errors++; $display("FAIL edge_pos got (%0d,%0d) (%0d,%0d)", p1_x, p1_y, p2_x, p2_y); end
        do_req(2, 2'd2, a1, a2, ok, cyc);
        checks++; if (ok !== 1'b1 || p2_x !== 10'd14 || p2_moves !== 16'd1) begin errors++; $display("FAIL edge_inward got ok=%b x=%0d m=%0d want 1 14 1", ok, p2_x, p2_moves); end
    endtask

    task automatic test_abort_and_reset();
        logic a1, a2, ok, seen;
        int cyc;
        load_level('0, 2, 2, 9, 9);
        do_req(1, 2'd3, a1, a2, ok, cyc);
        checks++; if (p1_moves !== 16'd1) begin errors++; $display("FAIL abort_pre got=%0d want=1", p1_moves); end
        p1_init_x = 10'd4; p1_init_y = 10'd5; p2_init_x = 10'd10; p2_init_y = 10'd3;
        p1_req = 1'b1; p1_dir = 2'd1;
        @(negedge clk);
        new_level = 1'b1; p1_req = 1'b0;
        seen = 1'b0;
        @(negedge clk); seen |= p1_ack | p2_ack;
        new_level = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_load got ready=%b want 0", ready); end
        repeat (2) begin @(negedge clk); seen |= p1_ack | p2_ack; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_noack got=%b want 0", seen); end
        checks++; if ({p1_x, p1_y, p2_x, p2_y} !== {10'd4, 10'd5, 10'd10, 10'd3}) begin errors++; $display("FAIL abort_pos got (%0d,%0d) (%0d,%0d) want (4,5) (10,3)", p1_x, p1_y, p2_x, p2_y); end
        checks++; if (p1_moves !== 16'd0 || ready !== 1'b1) begin errors++; $display("FAIL abort_moves got m=%0d rdy=%b want 0 1", p1_moves, ready); end
        p2_req = 1'b1; p2_dir = 2'd0;
        wait_ack(cyc);
        checks++; if (p2_ack !== 1'b1 || p2_ok !== 1'b1) begin errors++; $display("FAIL resp_pre got ack=%b ok=%b want 1 1", p2_ack, p2_ok); end
        #2 reset = 1'b1;
        #1;
        checks++; if (p2_ack !== 1'b0 || p2_ok !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL rst_async got ack=%b ok=%b rdy=%b want 0 0 0", p2_ack, p2_ok, ready); end
        checks++; if (p2_x !== 10'd0 || p2_y !== 10'd0 || p2_moves !== 16'd0) begin errors++; $display("FAIL rst_async_pos got (%0d,%0d) m=%0d want 0", p2_x, p2_y, p2_moves); end
        p2_req = 1'b0;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_wait got ready=%b want 0", ready); end
    endtask

    initial begin
        reset = 1'b1; new_level = 1'b0; mask = '0;
        p1_init_x = '0; p1_init_y = '0; p2_init_x = '0; p2_init_y = '0;
        p1_req = 1'b0; p2_req = 1'b0; p1_dir = '0; p2_dir = '0;
        test_reset();
        test_load();
        test_wall_and_move();
        test_round_robin();
        test_overlap();
        test_edges();
        test_abort_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
